// File: rtl/branch_history_table_pkg.sv
// branch_history_table_pkg: shared counter encodings and default table geometry
package branch_history_table_pkg;
  typedef enum logic [1:0] {SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11} cnt_e;
  localparam int DEF_INDEX_BITS = 4;
  localparam int DEF_TAG_BITS = 8;
  localparam int DEF_CNT_BITS = 16;
endpackage

// File: rtl/branch_history_table_sat_counter2.sv
// sat_counter2: combinational 2-bit saturating counter next state
//   cnt_i  : current counter (SNT/WNT/WT/ST)
//   taken  : resolved outcome, 1 counts up, 0 counts down
//   cnt_o  : next counter, clamped at SNT and ST
module sat_counter2
  import branch_history_table_pkg::*;
(
  input  logic [1:0] cnt_i,
  input  logic       taken,
  output logic [1:0] cnt_o
);
  always_comb begin
    cnt_o = taken ? ((cnt_i == ST) ? cnt_i : cnt_i + 2'd1)
                  : ((cnt_i == SNT) ? cnt_i : cnt_i - 2'd1);
  end
endmodule

// File: rtl/branch_history_table.sv
// branch_history_table: direct-mapped 2-bit branch predictor with BTFN fallback
//   predict_*   : lookup in, registered prediction/target/hit/out_valid one cycle later
//   update_*    : resolved outcome in, trains the table, registered mispredict
//   mispredict_count : saturating mispredict statistics
module branch_history_table
  import branch_history_table_pkg::*;
#(
  parameter int INDEX_BITS = DEF_INDEX_BITS,
  parameter int TAG_BITS   = DEF_TAG_BITS,
  parameter int CNT_BITS   = DEF_CNT_BITS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                predict_valid,
  input  logic [31:0]         predict_pc,
  input  logic [31:0]         predict_offset,
  output logic                prediction,
  output logic [31:0]         predict_target,
  output logic                predict_hit,
  output logic                predict_out_valid,
  input  logic                update_valid,
  input  logic [31:0]         update_pc,
  input  logic                update_taken,
  input  logic                update_predicted,
  output logic                mispredict,
  output logic [CNT_BITS-1:0] mispredict_count
);
  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_LO = INDEX_BITS + 2;
  localparam int TAG_HI = INDEX_BITS + TAG_BITS + 1;
  logic [ENTRIES-1:0]  valid_q, valid_d;
  logic [TAG_BITS-1:0] tag_q [ENTRIES];
  logic [TAG_BITS-1:0] tag_d [ENTRIES];
  logic [1:0]          cnt_q [ENTRIES];
  logic [1:0]          cnt_d [ENTRIES];
  logic                prediction_q, prediction_d;
  logic [31:0]         target_q, target_d;
  logic                hit_q, hit_d;
  logic                out_valid_q, out_valid_d;
  logic                mispredict_q, mispredict_d;
  logic [CNT_BITS-1:0] count_q, count_d;
  logic [INDEX_BITS-1:0] p_idx, u_idx;
  logic [TAG_BITS-1:0]   p_tag, u_tag;
  logic                  p_hit, u_hit;
  logic [1:0]            u_cnt_next;
  logic                  unused_pc_bits;
  assign p_idx = predict_pc[TAG_LO-1:2];
  assign p_tag = predict_pc[TAG_HI:TAG_LO];
  assign u_idx = update_pc[TAG_LO-1:2];
  assign u_tag = update_pc[TAG_HI:TAG_LO];
  assign p_hit = valid_q[p_idx] && (tag_q[p_idx] == p_tag);
  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
  assign unused_pc_bits = ^{predict_pc[31:TAG_HI+1], predict_pc[1:0],
                            update_pc[31:TAG_HI+1], update_pc[1:0]};
  sat_counter2 u_sat (
    .cnt_i (cnt_q[u_idx]),
    .taken (update_taken),
    .cnt_o (u_cnt_next)
  );
  // Lookup reads the current (pre-update) table, so a same-edge update is invisible to it.
  always_comb begin
    out_valid_d  = predict_valid;
    hit_d        = predict_valid && p_hit;
    prediction_d = predict_valid && (p_hit ? cnt_q[p_idx][1] : predict_offset[31]);
    target_d     = predict_pc + predict_offset;
    mispredict_d = update_valid && (update_taken != update_predicted);
    count_d      = (mispredict_d && !(&count_q)) ? count_q + CNT_BITS'(1) : count_q;
  end
  // A miss allocates over whatever alias occupies the slot (direct-mapped).
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    cnt_d   = cnt_q;
    if (update_valid) begin
      valid_d[u_idx] = 1'b1;
      tag_d[u_idx]   = u_tag;
      cnt_d[u_idx]   = u_hit ? u_cnt_next : (update_taken ? WT : WNT);
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q      <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i] <= '0;
        cnt_q[i] <= WNT;
      end
      prediction_q <= 1'b0;
      target_q     <= '0;
      hit_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      mispredict_q <= 1'b0;
      count_q      <= '0;
    end else begin
      valid_q      <= valid_d;
      tag_q        <= tag_d;
      cnt_q        <= cnt_d;
      prediction_q <= prediction_d;
      target_q     <= target_d;
      hit_q        <= hit_d;
      out_valid_q  <= out_valid_d;
      mispredict_q <= mispredict_d;
      count_q      <= count_d;
    end
  end
  assign prediction        = prediction_q;
  assign predict_target    = target_q;
  assign predict_hit       = hit_q;
  assign predict_out_valid = out_valid_q;
  assign mispredict        = mispredict_q;
  assign mispredict_count  = count_q;
endmodule

// File: tb/tb_branch_history_table.sv
// tb_branch_history_table: vector table, corner sequences and random model check
module tb_branch_history_table;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        predict_valid = 1'b0;
  logic [31:0] predict_pc = '0;
  logic [31:0] predict_offset = '0;
  logic        prediction;
  logic [31:0] predict_target;
  logic        predict_hit;
  logic        predict_out_valid;
  logic        update_valid = 1'b0;
  logic [31:0] update_pc = '0;
  logic        update_taken = 1'b0;
  logic        update_predicted = 1'b0;
  logic        mispredict;
  logic [15:0] mispredict_count;
  logic [1:0]  sc_in = '0;
  logic        sc_taken = 1'b0;
  logic [1:0]  sc_out;
  int total = 0;
  int bad = 0;
  branch_history_table dut (
    .clk               (clk),
    .reset             (reset),
    .predict_valid     (predict_valid),
    .predict_pc        (predict_pc),
    .predict_offset    (predict_offset),
    .prediction        (prediction),
    .predict_target    (predict_target),
    .predict_hit       (predict_hit),
    .predict_out_valid (predict_out_valid),
    .update_valid      (update_valid),
    .update_pc         (update_pc),
    .update_taken      (update_taken),
    .update_predicted  (update_predicted),
    .mispredict        (mispredict),
    .mispredict_count  (mispredict_count)
  );
  sat_counter2 u_sc (
    .cnt_i (sc_in),
    .taken (sc_taken),
    .cnt_o (sc_out)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic pv; logic [31:0] ppc; logic [31:0] poff;
    logic uv; logic [31:0] upc; logic ut; logic up;
    logic eov; logic ep; logic eh; logic [31:0] et; logic em; logic [15:0] ec;
  } vec_t;
  vec_t vecs [23];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  task automatic drive(input logic pv, input logic [31:0] ppc, input logic [31:0] poff,
                       input logic uv, input logic [31:0] upc, input logic ut, input logic up);
    predict_valid = pv; predict_pc = ppc; predict_offset = poff;
    update_valid = uv; update_pc = upc; update_taken = ut; update_predicted = up;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0);
    drive(1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0);
    reset = 1'b0;
  endtask
  function automatic logic [31:0] rand_pc();
    return ($urandom & 32'hFFFF_C003) | (32'($urandom_range(0, 2)) << 6) | (32'($urandom_range(0, 3)) << 2);
  endfunction
  initial begin
    for (int c = 0; c < 4; c++) begin
      for (int t = 0; t < 2; t++) begin
        int e;
        sc_in = 2'(c); sc_taken = t[0];
        #1;
        e = t ? ((c == 3) ? 3 : c + 1) : ((c == 0) ? 0 : c - 1);
        chk("sat_counter2", 32'(sc_out), 32'(e));
      end
    end
    vecs[0]  = '{1'b1, 32'h100, 32'hFFFFFFF0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0F0, 1'b0, 16'd0};
    vecs[1]  = '{1'b1, 32'h200, 32'h20, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h220, 1'b0, 16'd0};
    vecs[2]  = '{1'b1, 32'hFFFFFFF0, 32'h20, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h10, 1'b0, 16'd0};
    vecs[3]  = '{1'b0, 32'h10, 32'h4, 1'b1, 32'h200, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h14, 1'b1, 16'd1};
    vecs[4]  = '{1'b1, 32'h200, 32'h20, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h220, 1'b0, 16'd1};
    vecs[5]  = '{1'b0, 32'h0, 32'h0, 1'b1, 32'h200, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 16'd2};
    vecs[6]  = '{1'b0, 32'h0, 32'h0, 1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 16'd2};
    vecs[7]  = '{1'b1, 32'h200, 32'h20, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h220, 1'b0, 16'd2};
    vecs[8]  = '{1'b0, 32'h0, 32'h0, 1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 16'd2};
    vecs[9]  = '{1'b1, 32'h200, 32'h20, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h220, 1'b0, 16'd2};
    vecs[10] = '{1'b0, 32'h0, 32'h0, 1'b1, 32'h200, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 16'd2};
    vecs[11] = vecs[10];
    vecs[12] = vecs[10];
    vecs[13] = vecs[10];
    vecs[14] = '{1'b1, 32'h200, 32'h20, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h220, 1'b0, 16'd2};
    vecs[15] = vecs[8];
    vecs[16] = vecs[8];
    vecs[17] = '{1'b1, 32'h200, 32'h20, 1'b1, 32'h200, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h220, 1'b1, 16'd3};
    vecs[18] = '{1'b1, 32'h200, 32'h20, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h220, 1'b0, 16'd3};
    vecs[19] = '{1'b0, 32'h0, 32'h0, 1'b1, 32'h240, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 16'd4};
    vecs[20] = '{1'b1, 32'h200, 32'h20, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h220, 1'b0, 16'd4};
    vecs[21] = '{1'b1, 32'h240, 32'hFFFFFFF0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h230, 1'b0, 16'd4};
    vecs[22] = '{1'b1, 32'h200, 32'hFFFFFFF0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h1F0, 1'b0, 16'd4};
    do_reset();
    chk("reset out_valid", 32'(predict_out_valid), 32'd0);
    chk("reset prediction", 32'(prediction), 32'd0);
    chk("reset hit", 32'(predict_hit), 32'd0);
    chk("reset target", predict_target, 32'd0);
    chk("reset mispredict", 32'(mispredict), 32'd0);
    chk("reset count", 32'(mispredict_count), 32'd0);
    for (int i = 0; i < 23; i++) begin
      drive(vecs[i].pv, vecs[i].ppc, vecs[i].poff, vecs[i].uv, vecs[i].upc, vecs[i].ut, vecs[i].up);
      chk($sformatf("vec%0d out_valid", i), 32'(predict_out_valid), 32'(vecs[i].eov));
      chk($sformatf("vec%0d prediction", i), 32'(prediction), 32'(vecs[i].ep));
      chk($sformatf("vec%0d hit", i), 32'(predict_hit), 32'(vecs[i].eh));
      chk($sformatf("vec%0d target", i), predict_target, vecs[i].et);
      chk($sformatf("vec%0d mispredict", i), 32'(mispredict), 32'(vecs[i].em));
      chk($sformatf("vec%0d count", i), 32'(mispredict_count), 32'(vecs[i].ec));
    end
    update_valid = 1'b1; update_pc = 32'h300; update_taken = 1'b1; update_predicted = 1'b0;
    predict_valid = 1'b1; predict_pc = 32'h240; predict_offset = 32'h8;
    reset = 1'b1;
    #1;
    chk("async out_valid", 32'(predict_out_valid), 32'd0);
    chk("async prediction", 32'(prediction), 32'd0);
    chk("async hit", 32'(predict_hit), 32'd0);
    chk("async target", predict_target, 32'd0);
    chk("async count", 32'(mispredict_count), 32'd0);
    @(posedge clk);
    #1;
    chk("held mispredict", 32'(mispredict), 32'd0);
    reset = 1'b0;
    drive(1'b1, 32'h240, 32'h8, 1'b0, 0, 1'b0, 1'b0);
    chk("post reset hit 240", 32'(predict_hit), 32'd0);
    drive(1'b1, 32'h300, 32'h10, 1'b0, 0, 1'b0, 1'b0);
    chk("dropped update hit", 32'(predict_hit), 32'd0);
    chk("dropped update pred", 32'(prediction), 32'd0);
    begin
      bit mv [16];
      logic [7:0] mtag [16];
      int mcnt [16];
      int mcount = 0;
      do_reset();
      for (int i = 0; i < 16; i++) begin mv[i] = 1'b0; mtag[i] = '0; mcnt[i] = 1; end
      for (int c = 0; c < 400; c++) begin
        logic pv, uv, ut, up, hit, ep, em;
        logic [31:0] ppc, poff, upc, tmp;
        int pi, ui;
        pv = 1'($urandom_range(0, 1)); ppc = rand_pc(); poff = $urandom;
        uv = 1'($urandom_range(0, 1)); upc = rand_pc();
        ut = 1'($urandom_range(0, 1)); up = 1'($urandom_range(0, 1));
        pi = int'(ppc[5:2]); ui = int'(upc[5:2]);
        hit = pv && mv[pi] && (mtag[pi] == ppc[13:6]);
        tmp = poff;
        ep = pv && (hit ? (mcnt[pi] >= 2) : tmp[31]);
        em = uv && (ut != up);
        if (em && mcount < 65535) mcount++;
        if (uv) begin
          if (mv[ui] && mtag[ui] == upc[13:6])
            mcnt[ui] = ut ? ((mcnt[ui] < 3) ? mcnt[ui] + 1 : 3) : ((mcnt[ui] > 0) ? mcnt[ui] - 1 : 0);
          else begin
            mv[ui] = 1'b1; mtag[ui] = upc[13:6]; mcnt[ui] = ut ? 2 : 1;
          end
        end
        drive(pv, ppc, poff, uv, upc, ut, up);
        chk("rnd out_valid", 32'(predict_out_valid), 32'(pv));
        chk("rnd hit", 32'(predict_hit), 32'(hit));
        chk("rnd prediction", 32'(prediction), 32'(ep));
        chk("rnd target", predict_target, ppc + poff);
        chk("rnd mispredict", 32'(mispredict), 32'(em));
        chk("rnd count", 32'(mispredict_count), 32'(mcount));
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/branch_history_table.md
Name: branch_history_table

Overview:
- Dynamic conditional-branch predictor for the Sail RV32I core.
- Fetch/decode side: queries the table with a branch PC and immediate, and receives a registered taken/not-taken prediction plus target.
- Execute side: feeds the resolved outcome back (the ALU Branch_Enable result for BEQ/BNE/BLT/BGE/BLTU/BGEU) to train the table and flag mispredicts.
- It is the consumer/trainer at the other end of the ALU branch-resolution interface.

Parameters:
- INDEX_BITS, 4, log2 of entry count (16 entries); index = pc[INDEX_BITS+1:2].
- TAG_BITS, 8, tag width; tag = pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2].
- CNT_BITS, 16, width of the saturating mispredict statistics counter.

Ports:
- clk, input, 1, core clock; all state updates on rising edge.
- reset, input, 1, asynchronous, active-high; clears all state immediately.
- predict_valid, input, 1, a conditional branch sits at predict_pc this cycle.
- predict_pc, input, 32, PC of the branch being predicted.
- predict_offset, input, 32, sign-extended B-type immediate.
- prediction, output, 1, registered taken(1)/not-taken(0).
- predict_target, output, 32, registered predict_pc + predict_offset.
- predict_hit, output, 1, registered; the lookup matched a valid entry.
- predict_out_valid, output, 1, registered copy of predict_valid.
- update_valid, input, 1, a resolved branch is presented this cycle.
- update_pc, input, 32, PC of the resolved branch.
- update_taken, input, 1, actual outcome (ALU Branch_Enable).
- update_predicted, input, 1, prediction that was used for this branch.
- mispredict, output, 1, registered; update_valid & (update_taken != update_predicted).
- mispredict_count, output, CNT_BITS, saturating count of mispredicts.

Behaviour:
- Reset (async):
  - All valid bits are cleared and all counters set to WNT.
  - prediction, predict_target, predict_hit, predict_out_valid, mispredict and mispredict_count are 0 at once.
  - An update in flight at reset assertion is dropped.
- Entry format: valid, tag[TAG_BITS], 2-bit counter with encodings SNT=00, WNT=01, WT=10, ST=11.
- Lookup:
  - When predict_valid=1, index and tag are computed from predict_pc.
  - Hit = valid & tag match.
  - On a hit, the prediction is counter[1].
  - On a miss, the static fallback is backward-taken/forward-not-taken: prediction = predict_offset[31].
- Latency: outputs are registered, so results appear exactly 1 cycle after predict_valid.
- predict_valid=0: predict_out_valid=0, prediction=0, predict_hit=0; predict_target still tracks the registered sum.
- Target arithmetic: 32-bit add, wrapping modulo 2^32, with no overflow flag.
- Update on a hit:
  - Taken increments the counter, saturating at ST.
  - Not-taken decrements it, saturating at SNT.
- Update on a miss: the entry is allocated or replaced (direct-mapped) with valid=1, new tag, counter = update_taken ? WT : WNT.
- Mispredict path:
  - mispredict is registered, 1 cycle after update_valid.
  - mispredict_count increments on each mispredict and holds at all-ones.
  - The mispredict condition is independent of hit/miss.
- Simultaneous predict and update, same index:
  - The lookup sees the pre-update entry (read-before-write).
  - The update is committed at the same edge.
- Simultaneous different indices: both proceed independently.
- Table state changes only on update_valid; lookups never modify the table.

Decomposition:
- Shared defines header (alongside sail-core-defines):
  - counter encodings SNT/WNT/WT/ST;
  - default INDEX_BITS/TAG_BITS.
- One sub-module: sat_counter2, a combinational 2-bit saturating next-state (counter, taken -> next counter).
  - It is instantiated once on the update path.
  - It is unit-tested separately.

Test Plan:
1. Static fallback, backward: reset, then predict_valid with pc=0x100, offset=0xFFFFFFF0 -> next cycle hit=0, prediction=1, target=0x000000F0, out_valid=1.
2. Static fallback, forward: predict pc=0x200, offset=0x20 -> hit=0, prediction=0, target=0x220. Wrap check: pc=0xFFFFFFF0, offset=0x20 -> target=0x00000010.
3. Mispredict and allocate:
   - update pc=0x200, taken=1, predicted=0 -> next cycle mispredict=1, mispredict_count=1.
   - Then predict pc=0x200 -> hit=1, prediction=1 (entry WT).
4. Saturation:
   - From WT, two not-taken updates give WNT then SNT; predict -> 0.
   - A third not-taken stays SNT.
   - Four taken updates reach ST and stay there; predict -> 1.
   - Updates with update_predicted==update_taken -> mispredict=0, count unchanged.
5. Aliasing: after the 0x200 entry exists, update pc=0x240 (same index 0, different tag) with not-taken -> replaces the entry with WNT. Predict pc=0x200 -> hit=0, static fallback.
6. Edge cases:
   - Same-cycle predict and update on pc=0x200 with the counter at WNT and taken=1 -> prediction=0 (old state); the next lookup returns 1.
   - Assert reset asynchronously mid-sequence -> all outputs 0 before the next edge; any lookup afterwards misses.
